// File: rtl/pc_defs.sv
// Shared definitions for the PC sequencer: next-PC select encodings and parameter defaults.
// Latency: none (declarations only).
// Backpressure: none; the consumers are gated by the control unit's PCWre strobe.
package pc_defs;

  // Next-PC select encodings driven by the control unit on PCSrc
  typedef enum logic [1:0] {
    PC_SEQ = 2'b00,
    PC_BR  = 2'b01,
    PC_JMP = 2'b10,
    PC_RET = 2'b11
  } pc_src_e;

  // Default sequential increment in bytes
  localparam int unsigned INC_DEFAULT = 4;

  // Default PC value after reset
  localparam logic [31:0] RESET_VEC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: circular LIFO with a top pointer and a saturating entry count.
// Latency: push/pop take effect at the clock edge; top_dat_o, empty_o and full_o are registered-state views.
// Backpressure: none; a push when full overwrites the oldest entry and a pop when empty is ignored.
module pc_ras #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [ADDR_W-1:0] push_dat_i,
  output logic [ADDR_W-1:0] top_dat_o,
  output logic              empty_o,
  output logic              full_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  top_q, top_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wr_en;
  logic [PTR_W-1:0]  wr_idx;
  logic              pop_ok;

  // A pop on an empty stack is not a pop at all; the caller falls back to its own target
  assign pop_ok    = pop_i && !empty_o;
  assign empty_o   = (cnt_q == '0);
  assign full_o    = (cnt_q == CNT_W'(DEPTH));
  assign top_dat_o = mem_q[top_q];

  // Pointer/count next state; push+pop replaces the top entry in place so the depth is unchanged
  always_comb begin
    top_d  = top_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_idx = top_q;
    if (push_i && pop_ok) begin
      wr_en  = 1'b1;
      wr_idx = top_q;
    end else if (push_i) begin
      wr_en  = 1'b1;
      wr_idx = top_q + 1'b1;
      top_d  = top_q + 1'b1;
      if (cnt_q != CNT_W'(DEPTH)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (pop_ok) begin
      top_d = top_q - 1'b1;
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Pointer and count registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      top_q <= '0;
      cnt_q <= '0;
    end else begin
      top_q <= top_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage; cleared on reset so a fresh stack never exposes stale return addresses
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wr_idx] <= push_dat_i;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: holds the PC, selects SEQ/BR/JMP/RET successor, commits on PCWre. Optional RAS: PC_RAS_EN.
// Latency: pcPlus4/nextPc are combinational; pcOut and sticky flags update at the edge where PCWre=1.
// Backpressure: none; all state holds while PCWre=0 and PCWre held high commits every cycle.
module pc_sequencer
  import pc_defs::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       INC       = INC_DEFAULT,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(RESET_VEC_DEFAULT),
  parameter int unsigned       RAS_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              PCWre,
  input  logic [1:0]        PCSrc,
  input  logic              branchTaken,
  input  logic [15:0]       branchOffset,
  input  logic [25:0]       jumpTarget,
  input  logic [ADDR_W-1:0] jrTarget,
  input  logic              linkPush,
  output logic [ADDR_W-1:0] pcOut,
  output logic [ADDR_W-1:0] pcPlus4,
  output logic [ADDR_W-1:0] nextPc,
  output logic              misalign,
  output logic              rasEmpty,
  output logic              rasFull,
  output logic              rasUnderflow
);

  // Low 28 bits come from the jump field; the region bits above are kept from pcPlus4
  localparam logic [ADDR_W-1:0] JMP_LO_MASK = ADDR_W'(28'hFFF_FFFF);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              misalign_q, misalign_d;
  logic [ADDR_W-1:0] br_off;
  logic [ADDR_W-1:0] br_tgt;
  logic [ADDR_W-1:0] jmp_tgt;
  logic [ADDR_W-1:0] ret_tgt;
  logic [ADDR_W-1:0] next_pc;
  logic              ret_sel;

  assign pcPlus4 = pc_q + ADDR_W'(INC);
  assign br_off  = {{(ADDR_W-18){branchOffset[15]}}, branchOffset, 2'b00};
  assign br_tgt  = pcPlus4 + br_off;
  assign jmp_tgt = (pcPlus4 & ~JMP_LO_MASK) | ADDR_W'({jumpTarget, 2'b00});
  assign ret_sel = (pc_src_e'(PCSrc) == PC_RET);

`ifdef PC_RAS_EN
  logic [ADDR_W-1:0] ras_top;
  logic              ras_empty;
  logic              ras_full;
  logic              underflow_q, underflow_d;

  pc_ras #(
    .ADDR_W (ADDR_W),
    .DEPTH  (RAS_DEPTH)
  ) u_ras (
    .clk_i      (CLK),
    .rst_ni     (RST_n),
    .push_i     (PCWre && linkPush),
    .pop_i      (PCWre && ret_sel),
    .push_dat_i (pcPlus4),
    .top_dat_o  (ras_top),
    .empty_o    (ras_empty),
    .full_o     (ras_full)
  );

  // Prediction comes from the stack; an empty stack falls back to the register target
  assign ret_tgt     = ras_empty ? jrTarget : ras_top;
  assign underflow_d = underflow_q || (PCWre && ret_sel && ras_empty);

  // Sticky underflow flag
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      underflow_q <= 1'b0;
    end else begin
      underflow_q <= underflow_d;
    end
  end

  assign rasEmpty     = ras_empty;
  assign rasFull      = ras_full;
  assign rasUnderflow = underflow_q;
`else
  logic [31:0] unused_cfg;

  // Without the stack, returns always go through the register target and call markers are dropped
  assign ret_tgt      = jrTarget;
  assign unused_cfg   = {31'(RAS_DEPTH), linkPush};
  assign rasEmpty     = 1'b1;
  assign rasFull      = 1'b0;
  assign rasUnderflow = 1'b0;
`endif

  // Successor select; a not-taken branch degenerates to the sequential successor
  always_comb begin
    next_pc = pcPlus4;
    case (pc_src_e'(PCSrc))
      PC_SEQ: next_pc = pcPlus4;
      PC_BR:  next_pc = branchTaken ? br_tgt : pcPlus4;
      PC_JMP: next_pc = jmp_tgt;
      PC_RET: next_pc = ret_tgt;
      default: next_pc = pcPlus4;
    endcase
  end

  assign nextPc     = next_pc;
  assign pc_d       = PCWre ? next_pc : pc_q;
  assign misalign_d = misalign_q || (PCWre && (next_pc[1:0] != 2'b00));

  // PC register and sticky misalign flag; a misaligned target is still committed
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      pc_q       <= RESET_VEC;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

  assign pcOut    = pc_q;
  assign misalign = misalign_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; RAS-dependent expectations follow PC_RAS_EN.
// Latency: checks are sampled 1 time unit after the committing rising edge.
// Backpressure: none.
module tb_pc_sequencer;

`ifdef PC_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  logic        CLK;
  logic        RST_n;
  logic        PCWre;
  logic [1:0]  PCSrc;
  logic        branchTaken;
  logic [15:0] branchOffset;
  logic [25:0] jumpTarget;
  logic [31:0] jrTarget;
  logic        linkPush;
  logic [31:0] pcOut;
  logic [31:0] pcPlus4;
  logic [31:0] nextPc;
  logic        misalign;
  logic        rasEmpty;
  logic        rasFull;
  logic        rasUnderflow;

  int n_vec  = 0;
  int n_miss = 0;

  pc_sequencer dut (
    .CLK          (CLK),
    .RST_n        (RST_n),
    .PCWre        (PCWre),
    .PCSrc        (PCSrc),
    .branchTaken  (branchTaken),
    .branchOffset (branchOffset),
    .jumpTarget   (jumpTarget),
    .jrTarget     (jrTarget),
    .linkPush     (linkPush),
    .pcOut        (pcOut),
    .pcPlus4      (pcPlus4),
    .nextPc       (nextPc),
    .misalign     (misalign),
    .rasEmpty     (rasEmpty),
    .rasFull      (rasFull),
    .rasUnderflow (rasUnderflow)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic commit();
    PCWre = 1'b1;
    @(posedge CLK);
    #1;
    PCWre       = 1'b0;
    linkPush    = 1'b0;
    branchTaken = 1'b0;
    PCSrc       = 2'b00;
  endtask

  task automatic do_seq();
    PCSrc = 2'b00;
    commit();
  endtask

  task automatic do_jmp(input logic [25:0] jt, input logic link);
    PCSrc      = 2'b10;
    jumpTarget = jt;
    linkPush   = link;
    commit();
  endtask

  task automatic do_ret(input logic [31:0] jr, input logic link);
    PCSrc    = 2'b11;
    jrTarget = jr;
    linkPush = link;
    commit();
  endtask

  initial begin
    RST_n        = 1'b0;
    PCWre        = 1'b0;
    PCSrc        = 2'b00;
    branchTaken  = 1'b0;
    branchOffset = 16'h0000;
    jumpTarget   = 26'h0;
    jrTarget     = 32'h0;
    linkPush     = 1'b0;

    // reset state
    #12;
    chk("rst_pc", pcOut, 32'h0);
    chk("rst_pc4", pcPlus4, 32'h4);
    chk("rst_next", nextPc, 32'h4);
    chk("rst_misalign", {31'b0, misalign}, 32'h0);
    chk("rst_empty", {31'b0, rasEmpty}, 32'h1);
    chk("rst_full", {31'b0, rasFull}, 32'h0);
    chk("rst_uflow", {31'b0, rasUnderflow}, 32'h0);
    RST_n = 1'b1;

    // sequential commits
    do_seq(); chk("seq1", pcOut, 32'h4);
    do_seq(); chk("seq2", pcOut, 32'h8);
    do_seq(); chk("seq3", pcOut, 32'hC);

    // hold with PCWre low; a stray call marker must not touch the stack
    linkPush = 1'b1;
    repeat (5) @(posedge CLK);
    #1;
    chk("hold_pc", pcOut, 32'hC);
    chk("hold_empty", {31'b0, rasEmpty}, 32'h1);
    linkPush = 1'b0;

    // branch taken / not taken from 0x100
    do_jmp(26'h40, 1'b0); chk("jmp_100", pcOut, 32'h100);
    PCSrc = 2'b01; branchTaken = 1'b1; branchOffset = 16'hFFFC;
    #1;
    chk("br_next", nextPc, 32'hF4);
    commit(); chk("br_taken", pcOut, 32'hF4);
    do_jmp(26'h40, 1'b0); chk("jmp_100b", pcOut, 32'h100);
    PCSrc = 2'b01; branchTaken = 1'b0; branchOffset = 16'hFFFC;
    #1;
    chk("br_nt_next", nextPc, 32'h104);
    commit(); chk("br_not_taken", pcOut, 32'h104);

    // jump keeps region bits from pcPlus4
    do_ret(32'h1000_0040, 1'b0); chk("ret_jr", pcOut, 32'h1000_0040);
    chk("ret_jr_uflow", {31'b0, rasUnderflow}, {31'b0, RAS_ON});
    chk("pc4_hi", pcPlus4, 32'h1000_0044);
    do_jmp(26'h0000010, 1'b0); chk("jmp_region", pcOut, 32'h1000_0040);

    // reset before the stack section
    RST_n = 1'b0;
    #1;
    chk("rst2_pc", pcOut, 32'h0);
    chk("rst2_uflow", {31'b0, rasUnderflow}, 32'h0);
    #3;
    RST_n = 1'b1;

    // calls at 0x10..0x50
    do_jmp(26'h04, 1'b0); chk("to_10", pcOut, 32'h10);
    do_jmp(26'h08, 1'b1); chk("call_10", pcOut, 32'h20);
    chk("call_10_empty", {31'b0, rasEmpty}, {31'b0, !RAS_ON});
    do_jmp(26'h0C, 1'b1); chk("call_20", pcOut, 32'h30);
    do_jmp(26'h10, 1'b1); chk("call_30", pcOut, 32'h40);
    chk("three_full", {31'b0, rasFull}, 32'h0);
    do_jmp(26'h14, 1'b1); chk("call_40", pcOut, 32'h50);
    chk("four_full", {31'b0, rasFull}, {31'b0, RAS_ON});
    do_jmp(26'h18, 1'b1); chk("call_50", pcOut, 32'h60);
    chk("five_full", {31'b0, rasFull}, {31'b0, RAS_ON});

    // returns unwind newest first; oldest entry (0x14) was overwritten
    do_ret(32'h700, 1'b0); chk("ret1", pcOut, RAS_ON ? 32'h54 : 32'h700);
    do_ret(32'h710, 1'b0); chk("ret2", pcOut, RAS_ON ? 32'h44 : 32'h710);
    do_ret(32'h720, 1'b0); chk("ret3", pcOut, RAS_ON ? 32'h34 : 32'h720);
    do_ret(32'h730, 1'b0); chk("ret4", pcOut, RAS_ON ? 32'h24 : 32'h730);
    chk("ret4_empty", {31'b0, rasEmpty}, 32'h1);
    chk("ret4_full", {31'b0, rasFull}, 32'h0);
    chk("ret4_uflow", {31'b0, rasUnderflow}, 32'h0);
    do_ret(32'h200, 1'b0); chk("ret5", pcOut, 32'h200);
    chk("ret5_uflow", {31'b0, rasUnderflow}, {31'b0, RAS_ON});

    // simultaneous push and pop
    do_jmp(26'h14, 1'b0); chk("to_50", pcOut, 32'h50);
    do_jmp(26'h20, 1'b1); chk("call_50b", pcOut, 32'h80);
    do_ret(32'h600, 1'b1); chk("pushpop", pcOut, RAS_ON ? 32'h54 : 32'h600);
    chk("pushpop_empty", {31'b0, rasEmpty}, {31'b0, !RAS_ON});
    do_ret(32'h604, 1'b0); chk("pushpop_top", pcOut, RAS_ON ? 32'h84 : 32'h604);
    chk("pushpop_drained", {31'b0, rasEmpty}, 32'h1);

    // sticky misalign
    chk("pre_misalign", {31'b0, misalign}, 32'h0);
    do_ret(32'h203, 1'b0); chk("mis_pc", pcOut, 32'h203);
    chk("mis_set", {31'b0, misalign}, 32'h1);
    do_seq(); chk("mis_seq", pcOut, 32'h207);
    do_jmp(26'h80, 1'b1); chk("mis_jmp", pcOut, 32'h200);
    chk("mis_sticky1", {31'b0, misalign}, 32'h1);
    chk("mis_jmp_empty", {31'b0, rasEmpty}, {31'b0, !RAS_ON});
    do_seq(); chk("mis_seq2", pcOut, 32'h204);
    chk("mis_sticky2", {31'b0, misalign}, 32'h1);

    // reset asserted with a commit pending
    PCSrc = 2'b00;
    PCWre = 1'b1;
    #2;
    RST_n = 1'b0;
    #1;
    chk("arst_pc", pcOut, 32'h0);
    chk("arst_misalign", {31'b0, misalign}, 32'h0);
    chk("arst_uflow", {31'b0, rasUnderflow}, 32'h0);
    chk("arst_empty", {31'b0, rasEmpty}, 32'h1);
    @(posedge CLK);
    #1;
    chk("arst_hold", pcOut, 32'h0);
    PCWre = 1'b0;
    #3;
    RST_n = 1'b1;
    do_seq(); chk("post_rst_seq", pcOut, 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
